uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's 16x-oversampled UART receiver.
- Frame format: idle high, one low start bit, 8 data bits LSB first, stop bit(s) high (2 by default).
- Bit timing comes from the shared x16_BAUD clock-enable strobe: one bit = 16 strobes.
- Sits between a byte-producing host FSM and the serial pin; uses a simple send/ready handshake.

Parameters:
- P_BIT_TIME, 16, x16_BAUD ticks per bit; must be at least 2.
- P_STOP_BITS, 2, number of stop bits; legal values 1 or 2.

Ports:
- CLK  input  1  system clock; all state updates on the falling edge of CLK.
- reset  input  1  asynchronous, active-high reset.
- x16_BAUD  input  1  clock-enable strobe at 16x baud, one CLK cycle wide.
- Di  input  8  byte to transmit; sampled only on accept.
- send  input  1  request to transmit Di.
- ready  output  1  high when a new byte can be accepted.
- done  output  1  one-CLK pulse when the last stop bit has completed.
- serial_out  output  1  UART serial line; registered, idle high.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - serial_out=1, ready=1, done=0.
  - state=S_IDLE; counter, bit index and shift register cleared to 0.
  - Reset asserted mid-frame aborts the frame: line returns high at once and no done pulse is produced.
- Accept: on a CLK edge with send=1 and ready=1:
  - Di is latched into the shift register; ready drops on that edge; state goes to S_LOAD.
  - Accept does not require x16_BAUD.
  - send while ready=0 is ignored; no queuing.
  - Changes on Di after accept have no effect.
- State machine. Transitions occur only on edges where x16_BAUD=1, except accept and reset.
  - S_IDLE: serial_out=1, ready=1.
  - S_LOAD:
    - On the first tick, go to S_START with serial_out=0 and counter=0.
    - Start-bit latency: 1 to 2 ticks after accept, depending on strobe phase.
  - S_START: counter increments each tick. At the tick with counter==P_BIT_TIME-1:
    - go to S_DATA, bit index=0, serial_out=data[0], counter=0.
  - S_DATA: at the tick with counter==P_BIT_TIME-1:
    - if bit index==7: go to S_STOP (or S_PARITY, see Optional Feature), serial_out=1, counter=0.
    - otherwise: increment bit index and drive the next bit, LSB first.
  - S_STOP: lasts P_STOP_BITS*P_BIT_TIME ticks. At the final tick:
    - go to S_IDLE, ready=1, done=1 for exactly one CLK cycle.
- Each bit is held for exactly P_BIT_TIME ticks.
- Frame length is (1+8+P_STOP_BITS)*P_BIT_TIME ticks, i.e. 176 ticks at defaults.
- Back-to-back frames:
  - send may be held high; the next accept happens on the edge after ready rises.
  - The line stays high for the full stop time, plus at most one tick before the next start bit.
- Counter width covers P_STOP_BITS*P_BIT_TIME-1 without overflow.
- Illegal state values recover to S_IDLE with serial_out=1 on the next tick.
- x16_BAUD held high continuously is legal: every CLK edge counts as a tick.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - S_PARITY is inserted after data bit 7, lasting P_BIT_TIME ticks.
  - serial_out = XOR of the 8 latched data bits (even parity).
  - Frame length is (1+8+1+P_STOP_BITS)*P_BIT_TIME ticks.
- When undefined: no parity state or logic is compiled in; frame goes directly from data to stop, matching the receiver's default format.

Test Plan:
- Single byte: x16_BAUD every 4 CLK, reset released, send 0x55 for 1 CLK -> serial_out shows start 0, then 1,0,1,0,1,0,1,0, then 32 ticks high. Each bit is 64 CLK. done pulses once, 1 CLK wide; ready returns to 1.
- Back-to-back: send held high with Di=0x00 then 0xFF -> two complete frames with no extra gap beyond 1 tick. Each frame has 8 zeros or 8 ones. Exactly 2 done pulses.
- Busy rejection: during 0x3C data bits, pulse send with Di=0xC3 -> transmitted frame is still 0x3C; ready stays 0; only one done pulse.
- Reset mid-frame: assert reset during data bit 4 of 0xA5 -> serial_out=1 and ready=1 immediately with no CLK edge needed; done stays 0; next send 0x12 transmits cleanly.
- Loopback: connect serial_out to the team receiver's serial_in, send 0xA5 after the receiver has seen more than 160 idle ticks -> receiver outputs Do=0xA5, valid pulses, error=0.
- Parity (UART_TX_PARITY_EN defined): send 0x07 -> parity bit 1 after bit 7; send 0x03 -> parity bit 0; frame length 192 ticks.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx: UART transmitter timed by a shared 16x-baud clock-enable strobe.
//
// Frame: idle high, one low start bit, 8 data bits LSB first, optional even
// parity bit, then P_STOP_BITS high stop bits. Every bit is held for exactly
// P_BIT_TIME strobe ticks. All state updates happen on the falling edge of CLK.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   defined   -> an even-parity bit (XOR of the 8 data bits) follows data bit 7.
//   undefined -> no parity state or logic; data bit 7 is followed by stop bits.
//
// Parameters:
//   P_BIT_TIME   x16_BAUD ticks per bit (>= 2, default 16)
//   P_STOP_BITS  number of stop bits, 1 or 2 (default 2)
//
// Ports:
//   CLK         in   system clock, falling edge active
//   reset       in   asynchronous, active-high reset
//   x16_BAUD    in   one-CLK-wide clock-enable strobe at 16x baud
//   Di[7:0]     in   byte to transmit, sampled only on accept
//   send        in   transmit request; accepted when ready is high
//   ready       out  high when a new byte can be accepted
//   done        out  one-CLK pulse when the last stop bit has completed
//   serial_out  out  registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned P_BIT_TIME  = 16,
  parameter int unsigned P_STOP_BITS = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       x16_BAUD,
  input  logic [7:0] Di,
  input  logic       send,
  output logic       ready,
  output logic       done,
  output logic       serial_out
);

  // The stop phase is the longest single-counter interval, so it sizes the counter.
  localparam int unsigned StopTicks = P_STOP_BITS * P_BIT_TIME;
  localparam int unsigned CntW      = (StopTicks > 1) ? $clog2(StopTicks) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(P_BIT_TIME - 1);
  localparam logic [CntW-1:0] StopLast = CntW'(StopTicks - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
    StStop   = 3'd4,
    StParity = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StStart = 3'd2,
    StData  = 3'd3,
    StStop  = 3'd4
  } state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            serial_q, serial_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;

  logic       tick;
  logic       accept;
  logic       bit_end;
  logic       stop_end;
  logic [2:0] idx_nxt;

  assign tick     = x16_BAUD;
  assign accept   = send & ready_q;
  assign bit_end  = (cnt_q == BitLast);
  assign stop_end = (cnt_q == StopLast);
  assign idx_nxt  = idx_q + 3'd1;

  // ---------------------------------------------------------------------------
  // State register: every piece of state, falling-edge clocked.
  // ---------------------------------------------------------------------------
  always_ff @(negedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: state, bit-time counter, bit index, latched byte.
  // Only accept happens off-strobe; every other move waits for a tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StLoad;
          data_d  = Di;
        end
      end

      // Waits for the next strobe so the start bit is aligned to the tick grid.
      StLoad: begin
        if (tick) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end

      StStart: begin
        if (tick) begin
          if (bit_end) begin
            state_d = StData;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      StData: begin
        if (tick) begin
          if (bit_end) begin
            cnt_d = '0;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              idx_d = idx_nxt;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          if (bit_end) begin
            state_d = StStop;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end
`endif

      // One continuous count covers all stop bits.
      StStop: begin
        if (tick) begin
          if (stop_end) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      // Unreachable encodings fall back to idle on the next tick.
      default: begin
        if (tick) begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered line, ready and done. Each
  // line change coincides with the state transition that starts the new bit,
  // so the line is glitch-free and exactly bit-aligned.
  // ---------------------------------------------------------------------------
  always_comb begin
    serial_d = serial_q;
    ready_d  = ready_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        ready_d  = ~accept;
      end

      StLoad: begin
        if (tick) begin
          serial_d = 1'b0;
        end
      end

      StStart: begin
        if (tick && bit_end) begin
          serial_d = data_q[0];
        end
      end

      StData: begin
        if (tick && bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            serial_d = ^data_q;
`else
            serial_d = 1'b1;
`endif
          end else begin
            serial_d = data_q[idx_nxt];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (tick && bit_end) begin
          serial_d = 1'b1;
        end
      end
`endif

      StStop: begin
        if (tick && stop_end) begin
          serial_d = 1'b1;
          ready_d  = 1'b1;
          done_d   = 1'b1;
        end
      end

      default: begin
        if (tick) begin
          serial_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
    endcase
  end

  assign serial_out = serial_q;
  assign ready      = ready_q;
  assign done       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx: scoreboard bench for uart_tx. The driver pushes each byte it
// expects on the line; an independent frame monitor watches serial_out,
// pops the expected byte at each start bit and checks every CLK cycle of every
// bit, plus done/ready at the frame end. DUT is falling-edge clocked, so the
// bench drives and samples on the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif
  localparam int NBits = 1 + 8 + Par + 2;

  logic       CLK;
  logic       reset;
  logic       x16_BAUD;
  logic [7:0] Di;
  logic       send;
  logic       ready;
  logic       done;
  logic       serial_out;

  uart_tx #(
    .P_BIT_TIME (16),
    .P_STOP_BITS(2)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .x16_BAUD  (x16_BAUD),
    .Di        (Di),
    .send      (send),
    .ready     (ready),
    .done      (done),
    .serial_out(serial_out)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int baud_div = 4;
  int baud_cnt = 0;
  bit mon_busy = 0;

  logic [7:0] exp_q[$];
  int         start_cyc[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) cyc++;

  // Strobe one CLK in every baud_div; baud_div==1 holds it high.
  always @(posedge CLK) begin
    if (baud_cnt + 1 >= baud_div) baud_cnt = 0;
    else baud_cnt = baud_cnt + 1;
    x16_BAUD = (baud_cnt == 0);
  end

  always @(posedge CLK) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Frame monitor / scoreboard consumer.
  initial begin : monitor
    logic [7:0] b;
    logic       eb[0:11];
    int         bclk;
    int         errs;
    bit         aborted;
    forever begin
      @(posedge CLK);
      if (reset || serial_out !== 1'b0) continue;
      mon_busy = 1;
      start_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got a start bit, required none queued");
        b = 8'h00;
      end else begin
        b = exp_q.pop_front();
      end
      bclk = 16 * baud_div;
      eb[0] = 1'b0;
      for (int i = 0; i < 8; i++) eb[i+1] = b[i];
      if (Par == 1) eb[9] = ^b;
      for (int i = 9 + Par; i < NBits; i++) eb[i] = 1'b1;
      aborted = 0;
      for (int k = 0; k < NBits && !aborted; k++) begin
        errs = 0;
        for (int c = 0; c < bclk; c++) begin
          if (k != 0 || c != 0) @(posedge CLK);
          if (reset) begin
            aborted = 1;
            break;
          end
          if (serial_out !== eb[k]) errs++;
          if (k == 0 && c == bclk / 2) chk("ready_low_in_frame", ready, 1'b0);
        end
        if (!aborted) chk($sformatf("byte_%02h_bit%0d_wrong_cycles", b, k), errs, 0);
      end
      if (!aborted) begin
        @(posedge CLK);
        chk("done_at_frame_end", done, 1'b1);
        chk("ready_at_frame_end", ready, 1'b1);
        @(posedge CLK);
        chk("done_one_cycle", done, 1'b0);
      end
      mon_busy = 0;
    end
  end

  task automatic wait_ready(input logic lvl, input int limit, input string name);
    int n = 0;
    while (ready !== lvl && n < limit) begin
      @(posedge CLK);
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got ready=%b required %b", name, ready, lvl);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ready(1'b1, 5000, "send_wait_ready");
    Di   = b;
    send = 1'b1;
    exp_q.push_back(b);
    @(posedge CLK);
    wait_ready(1'b0, 10, "send_accept");
    send = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || ready !== 1'b1) && n < 20000) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got queue=%0d busy=%0d required 0 0", exp_q.size(), mon_busy);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int gap;
    int frame_clks;
    reset = 1'b1;
    send  = 1'b0;
    Di    = 8'h00;
    repeat (3) @(posedge CLK);
    chk("reset_serial", serial_out, 1'b1);
    chk("reset_ready", ready, 1'b1);
    chk("reset_done", done, 1'b0);
    #2 reset = 1'b0;

    // Single byte, alternating pattern.
    send_byte(8'h55);
    exp_done++;
    wait_idle();
    chk("done_count_single", done_cnt, exp_done);

    // Back-to-back with send held high.
    start_cyc.delete();
    wait_ready(1'b1, 5000, "b2b_ready");
    Di   = 8'h00;
    send = 1'b1;
    exp_q.push_back(8'h00);
    @(posedge CLK);
    wait_ready(1'b0, 10, "b2b_accept0");
    Di = 8'hFF;
    exp_q.push_back(8'hFF);
    wait_ready(1'b1, 2000, "b2b_ready1");
    wait_ready(1'b0, 10, "b2b_accept1");
    send = 1'b0;
    exp_done += 2;
    wait_idle();
    chk("done_count_b2b", done_cnt, exp_done);
    frame_clks = NBits * 16 * baud_div;
    total++;
    if (start_cyc.size() != 2) begin
      bad++;
      $display("FAIL b2b_frames: got %0d frames required 2", start_cyc.size());
    end else begin
      gap = start_cyc[1] - start_cyc[0];
      if (gap < frame_clks + 1 || gap > frame_clks + baud_div) begin
        bad++;
        $display("FAIL b2b_gap: got %0d cycles required %0d..%0d", gap, frame_clks + 1,
                 frame_clks + baud_div);
      end
    end

    // Busy rejection: a send during data bits must be ignored.
    send_byte(8'h3C);
    exp_done++;
    repeat (300) @(posedge CLK);
    Di   = 8'hC3;
    send = 1'b1;
    @(posedge CLK);
    chk("busy_ready_low", ready, 1'b0);
    send = 1'b0;
    wait_idle();
    chk("done_count_busy", done_cnt, exp_done);

    // Reset during data bit 4 aborts the frame without a done pulse.
    send_byte(8'hA5);
    repeat (350) @(posedge CLK);
    #2 reset = 1'b1;
    #1;
    chk("abort_serial", serial_out, 1'b1);
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    repeat (2) @(posedge CLK);
    #2 reset = 1'b0;
    chk("done_count_abort", done_cnt, exp_done);
    chk("abort_queue", exp_q.size(), 0);
    send_byte(8'h12);
    exp_done++;
    wait_idle();

    // Strobe held high: every CLK edge is a tick.
    baud_div = 1;
    @(posedge CLK);
    send_byte(8'h5A);
    exp_done++;
    wait_idle();
    baud_div = 4;
    repeat (8) @(posedge CLK);

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07);
    exp_done++;
    wait_idle();
    send_byte(8'h03);
    exp_done++;
    wait_idle();
`endif

    chk("done_count_final", done_cnt, exp_done);
    chk("queue_empty_final", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
